pwm_duty_ramp: RTL and testbench

//   Upstream duty-cycle sequencer for pwm_basico: drives its R-bit ciclo input with a

---
 rtl/pwm_duty_ramp.sv | 132 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Triangular duty-cycle sequencer for pwm_basico: rise, hold at max, fall, hold at zero.
// Duty only changes on PWM-period boundaries derived from an internal copy of the PWM timing.
module pwm_duty_ramp #(
    parameter int unsigned R            = 6,
    parameter int unsigned N            = 1600,
    parameter int unsigned STEP_PERIODS = 1,
    parameter int unsigned HOLD_PERIODS = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [R-1:0] ciclo_o,
    output logic         period_tick_o,
    output logic         ramp_up_o,
    output logic         cycle_done_o
);

    localparam int unsigned PreW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned StepW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned HoldW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [R-1:0]     DutyMax  = '1;
    localparam logic [R-1:0]     DutyOne  = R'(1);
    localparam logic [PreW-1:0]  PreLast  = PreW'(N - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_PERIODS - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_PERIODS - 1);

    typedef enum logic [2:0] {StIdle, StRise, StHoldHi, StFall, StHoldLo} state_e;

    state_e           state_q;
    logic [R-1:0]     ciclo_q;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [R-1:0]     per_q, per_d;
    logic [StepW-1:0] step_q;
    logic [HoldW-1:0] hold_q;
    logic             tick_q, tick_d;
    logic             ramp_up_q, cycle_done_q;
    logic             pre_wrap, step_evt, hold_done;

    // Tick is registered from the next counter values so it lands on the last clock of a period.
    always_comb begin
        pre_wrap  = (pre_q == PreLast);
        pre_d     = pre_wrap ? '0 : pre_q + 1'b1;
        per_d     = pre_wrap ? per_q + 1'b1 : per_q;
        tick_d    = (pre_d == PreLast) && (per_d == DutyMax);
        step_evt  = tick_q && (step_q == StepLast);
        hold_done = (HOLD_PERIODS == 0) || (tick_q && (hold_q == HoldLast));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ciclo_q      <= '0;
            pre_q        <= '0;
            per_q        <= '0;
            step_q       <= '0;
            hold_q       <= '0;
            tick_q       <= 1'b0;
            ramp_up_q    <= 1'b0;
            cycle_done_q <= 1'b0;
        end else if (!en_i) begin
            state_q      <= StIdle;
            ciclo_q      <= '0;
            pre_q        <= '0;
            per_q        <= '0;
            step_q       <= '0;
            hold_q       <= '0;
            tick_q       <= 1'b0;
            ramp_up_q    <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            cycle_done_q <= 1'b0;
            if (state_q == StIdle) begin
                state_q   <= StRise;
                ramp_up_q <= 1'b1;
            end else begin
                pre_q  <= pre_d;
                per_q  <= per_d;
                tick_q <= tick_d;
                if (tick_q) begin
                    step_q <= (step_q == StepLast) ? '0 : step_q + 1'b1;
                end
                unique case (state_q)
                    StRise: begin
                        if (step_evt) begin
                            ciclo_q <= ciclo_q + 1'b1;
                            if (ciclo_q == DutyMax - 1'b1) begin
                                state_q <= StHoldHi;
                                hold_q  <= '0;
                            end
                        end
                    end
                    StHoldHi: begin
                        if (hold_done) begin
                            state_q   <= StFall;
                            ramp_up_q <= 1'b0;
                            step_q    <= '0;
                        end else if (tick_q) begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    StFall: begin
                        if (step_evt) begin
                            ciclo_q <= ciclo_q - 1'b1;
                            if (ciclo_q == DutyOne) begin
                                state_q <= StHoldLo;
                                hold_q  <= '0;
                            end
                        end
                    end
                    StHoldLo: begin
                        if (hold_done) begin
                            state_q      <= StRise;
                            ramp_up_q    <= 1'b1;
                            cycle_done_q <= 1'b1;
                            step_q       <= '0;
                        end else if (tick_q) begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ciclo_o       = ciclo_q;
    assign period_tick_o = tick_q;
    assign ramp_up_o     = ramp_up_q;
    assign cycle_done_o  = cycle_done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with R=3, N=4, STEP=1; HOLD=2 and HOLD=0 instances share en.
// Expected outputs come from closed-form breath profiles indexed by clocks since RISE entry.
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] ciclo2, ciclo0;
    logic       tick2, tick0, ramp2, ramp0, done2, done0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.R(3), .N(4), .STEP_PERIODS(1), .HOLD_PERIODS(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .ciclo_o      (ciclo2),
        .period_tick_o(tick2),
        .ramp_up_o    (ramp2),
        .cycle_done_o (done2)
    );

    pwm_duty_ramp #(.R(3), .N(4), .STEP_PERIODS(1), .HOLD_PERIODS(0)) dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .ciclo_o      (ciclo0),
        .period_tick_o(tick0),
        .ramp_up_o    (ramp0),
        .cycle_done_o (done0)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // HOLD=2: breath of 18 periods (576 clks); period index p within breath.
    function automatic int exp_ciclo2(input int k);
        int p = (k / 32) % 18;
        if (p < 7) return p;
        if (p < 10) return 7;
        if (p < 17) return 16 - p;
        return 0;
    endfunction

    function automatic int exp_ramp2(input int k);
        return (((k / 32) % 18) <= 8) ? 1 : 0;
    endfunction

    function automatic int exp_done2(input int k);
        return (k >= 576 && (k % 576) == 0) ? 1 : 0;
    endfunction

    // HOLD=0: breath of 14 periods (448 clks); max visible for one period.
    function automatic int exp_ciclo0(input int k);
        int p = (k / 32) % 14;
        return (p <= 7) ? p : 14 - p;
    endfunction

    function automatic int exp_ramp0(input int k);
        int kk = k % 448;
        return ((kk <= 224) && !(kk == 0 && k > 0)) ? 1 : 0;
    endfunction

    function automatic int exp_done0(input int k);
        return (k >= 448 && (k % 448) == 1) ? 1 : 0;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, " ciclo2"}, int'(ciclo2), 0);
        check_eq({tag, " tick2"}, int'(tick2), 0);
        check_eq({tag, " ramp2"}, int'(ramp2), 0);
        check_eq({tag, " done2"}, int'(done2), 0);
        check_eq({tag, " ciclo0"}, int'(ciclo0), 0);
        check_eq({tag, " done0"}, int'(done0), 0);
    endtask

    // Samples n clocks on the falling edge, k counting clocks since RISE entry.
    task automatic run_profile(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq({tag, " ciclo2"}, int'(ciclo2), exp_ciclo2(k));
            check_eq({tag, " tick2"}, int'(tick2), ((k % 32) == 31) ? 1 : 0);
            check_eq({tag, " ramp2"}, int'(ramp2), exp_ramp2(k));
            check_eq({tag, " done2"}, int'(done2), exp_done2(k));
            check_eq({tag, " ciclo0"}, int'(ciclo0), exp_ciclo0(k));
            check_eq({tag, " tick0"}, int'(tick0), ((k % 32) == 31) ? 1 : 0);
            check_eq({tag, " ramp0"}, int'(ramp0), exp_ramp0(k));
            check_eq({tag, " done0"}, int'(done0), exp_done0(k));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle_en0");

        // Three full breaths plus breath four up to ciclo=4 in FALL.
        en = 1'b1;
        run_profile("breath", 3 * 576 + 401);
        check_eq("pre_drop ciclo2", int'(ciclo2), 4);
        check_eq("pre_drop ramp2", int'(ramp2), 0);

        en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_idle("drop_en");
        end

        // Restart: fresh alignment, first tick 32 clocks after RISE entry.
        en = 1'b1;
        run_profile("restart", 100);

        // Asynchronous reset in the middle of a low clock phase.
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        check_idle("async_rst_held");
        rst_n = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
